// File: rtl/idec_pkg.sv
// Shared types, opcode constants and the combinational ARM field decoder for idecoder_pipe.
// Optional macro IDEC_UNDEF_TRAP_EN: when defined, the decoder flags instr[27:26]==11 as undefined.
package idec_pkg;

    // The bundle carries a fixed-width PC; the pipe zero-extends or truncates to its own PC_W.
    localparam int IDEC_PC_W = 32;

    localparam logic [2:0] OPC_SYS   = 3'b000;
    localparam logic [2:0] OPC_IMM   = 3'b001;
    localparam logic [2:0] OPC_REG   = 3'b010;
    localparam logic [2:0] OPC_RSR   = 3'b011;
    localparam logic [2:0] OPC_LS    = 3'b101;
    localparam logic [3:0] OPC_BR    = 4'b1000;
    localparam logic [6:0] OPC_UNDEF = 7'b1010000;

    // Matched against instr[27:21].
    localparam logic [6:0] NOP_PAT  = 7'b0011001;
    localparam logic [6:0] HALT_PAT = 7'b0001000;

    typedef struct packed {
        logic [IDEC_PC_W-1:0] pc;
        logic [3:0]           cond;
        logic [6:0]           opcode;
        logic                 en_status;
        logic [3:0]           rn;
        logic [3:0]           rd;
        logic [3:0]           rs;
        logic [3:0]           rm;
        logic [1:0]           shift_op;
        logic [4:0]           imm5;
        logic [11:0]          imm12;
        logic [23:0]          imm24;
        logic                 undef;
    } idec_bundle_t;

    // pc is left zero; the caller fills it in.
    function automatic idec_bundle_t idec_decode(input logic [31:0] instr);
        idec_bundle_t b;
        b           = '0;
        b.cond      = instr[31:28];
        b.en_status = instr[20];
        b.rn        = instr[19:16];
        b.rd        = instr[15:12];
        b.rs        = instr[11:8];
        b.rm        = instr[3:0];
        b.shift_op  = instr[7:6];
        b.imm5      = instr[4:0];
        b.imm12     = instr[11:0];
        b.imm24     = instr[23:0];
        case (instr[27:26])
            2'b00: begin
                if (instr[27:21] == NOP_PAT || instr[27:21] == HALT_PAT)
                    b.opcode = {OPC_SYS, instr[24:21]};
                else if (instr[25])
                    b.opcode = {OPC_IMM, instr[24:21]};
                else if (instr[4])
                    b.opcode = {OPC_RSR, instr[24:21]};
                else
                    b.opcode = {OPC_REG, instr[24:21]};
            end
            2'b01:   b.opcode = {OPC_LS, instr[24:21]};
            2'b10:   b.opcode = {OPC_BR, instr[23:21]};
            default: begin
                b.opcode = OPC_UNDEF;
`ifdef IDEC_UNDEF_TRAP_EN
                b.undef  = 1'b1;
`endif
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/idec_fifo.sv
// Circular queue of {pc, instr} pairs with push/pop/flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module idec_fifo #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [31:0]                push_instr,
    input  logic                       pop,
    output logic [PC_W-1:0]            head_pc,
    output logic [31:0]                head_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PC_W+31:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign do_push    = push && !flush && !full;
    assign do_pop     = pop && !flush && !empty;
    assign empty      = (count == '0);
    assign full       = (count == OCC_W'(DEPTH));
    assign occupancy  = count;
    assign head_pc    = mem[rd_ptr][PC_W+31:32];
    assign head_instr = mem[rd_ptr][31:0];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {push_pc, push_instr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/idecoder_pipe.sv
// Buffered ARM instruction-decode stage: queue, combinational decode of the head, output register.
// Optional macro IDEC_UNDEF_TRAP_EN: flag undefined instructions and freeze fetch until flush.
module idecoder_pipe
    import idec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [3:0]                 cond,
    output logic [6:0]                 opcode,
    output logic                       en_status,
    output logic [3:0]                 rn,
    output logic [3:0]                 rd,
    output logic [3:0]                 rs,
    output logic [3:0]                 rm,
    output logic [1:0]                 shift_op,
    output logic [4:0]                 imm5,
    output logic [11:0]                imm12,
    output logic [23:0]                imm24,
    output logic                       out_undef,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    // Handshake: an instruction is taken on any edge where in_valid && in_ready; a bundle is
    // consumed on any edge where out_valid && out_ready. in_ready never depends on in_valid, and
    // out_valid/bundle fields never change while out_valid && !out_ready.

    logic [PC_W-1:0] head_pc;
    logic [31:0]     head_instr;
    logic            fifo_empty;
    logic            fifo_full;

    logic            armed;
    logic            frozen;
    logic            out_valid_q;
    idec_bundle_t    bundle_q;

    logic            retire;
    logic            load_slot;
    logic            accept;
    logic            pop;
    logic            bypass;
    logic            push;
    logic [31:0]     src_instr;
    logic [PC_W-1:0] src_pc;
    idec_bundle_t    next_bundle;

    always_comb begin
        retire    = out_valid_q && out_ready;
        load_slot = (!out_valid_q || retire) && !frozen;
        in_ready  = armed && !fifo_full && !flush && !frozen;
        accept    = in_valid && in_ready;
        pop       = load_slot && !fifo_empty && !flush;
        bypass    = load_slot && fifo_empty && accept;
        push      = accept && !bypass;
        // With an empty queue the incoming word is decoded directly for single-cycle latency.
        src_instr = fifo_empty ? in_instr : head_instr;
        src_pc    = fifo_empty ? in_pc    : head_pc;
        next_bundle    = idec_decode(src_instr);
        next_bundle.pc = IDEC_PC_W'(src_pc);
    end

    idec_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .push_pc    (in_pc),
        .push_instr (in_instr),
        .pop        (pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .occupancy  (occupancy),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            armed <= 1'b1;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else begin
                if (retire)
                    out_valid_q <= 1'b0;
                if (pop || bypass) begin
                    out_valid_q <= 1'b1;
                    bundle_q    <= next_bundle;
                end
            end
        end
    end

`ifdef IDEC_UNDEF_TRAP_EN
    // Once an undefined bundle is loaded, fetch and queue advance stay blocked until flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frozen <= 1'b0;
        else if (flush)
            frozen <= 1'b0;
        else if ((pop || bypass) && next_bundle.undef)
            frozen <= 1'b1;
    end
`else
    assign frozen = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_pc    = PC_W'(bundle_q.pc);
    assign cond      = bundle_q.cond;
    assign opcode    = bundle_q.opcode;
    assign en_status = bundle_q.en_status;
    assign rn        = bundle_q.rn;
    assign rd        = bundle_q.rd;
    assign rs        = bundle_q.rs;
    assign rm        = bundle_q.rm;
    assign shift_op  = bundle_q.shift_op;
    assign imm5      = bundle_q.imm5;
    assign imm12     = bundle_q.imm12;
    assign imm24     = bundle_q.imm24;
    assign out_undef = bundle_q.undef;

endmodule
